motion_record_packer: RTL and testbench
=======================================

// Module: motion_record_packer
// PURPOSE
//  Sits between the SNN motion detector and the Ascon-128 AEAD input stream.
//  Captures one 64-bit motion record per completed frame and buffers records in a small FIFO.
//  Presents them as an AXI-Stream master matching the cipher's 64-bit s_axis port.
//  Asserts tlast on every FRAMES_PER_MSG-th record, so each Ascon message covers a fixed frame group.
// PARAMETERS
//  FIFO_DEPTH      4   record slots; power of 2, >=2
//  FRAMES_PER_MSG  4   records per AEAD message (tlast period); >=1
// PORTS
//  clk               in   1   clock
//  rst_n             in   1   reset, asynchronous, active-low
//  enable            in   1   1 = capture frames; 0 = ignore frame_done (drain continues)
//  frame_done        in   1   1-cycle pulse from motion detector, end of frame
//  motion_detected   in   1   detector result, valid with frame_done
//  motion_intensity  in   8   detector result, valid with frame_done
//  grid_activity     in   16  per-cell activity bitmap, valid with frame_done
//  event_count       in   16  spike events in frame, valid with frame_done
//  m_axis_tvalid     out  1   record available
//  m_axis_tready     in   1   consumer accepts
//  m_axis_tdata      out  64  record (format below)
//  m_axis_tlast      out  1   last record of message
//  fifo_level        out  $clog2(FIFO_DEPTH)+1  occupied slots
//  drop_count        out  8   frames dropped on full FIFO, saturating
// BEHAVIOUR
//  Reset values: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, fifo_level=0, drop_count=0.
//   Also cleared: seq=0, msg_cnt=0, ovf_flag=0.
//  Record: [63:48] seq, [47] motion_detected, [46] ovf_flag, [45:40] 0,
//   [39:32] motion_intensity, [31:16] grid_activity, [15:0] event_count.
//  Frame event = frame_done & enable. Each frame event does three things:
//   - builds the record from the current inputs and seq;
//   - increments seq mod 2^16 (0xFFFF->0x0000), whether the record is kept or dropped;
//   - leaves gaps in seq that reveal drops to the receiver.
//  push = frame event & (!full | pop); pop = m_axis_tvalid & m_axis_tready.
//  Full FIFO with a pop in the same cycle: the push is accepted and the level is unchanged.
//  Dropped frame (frame event & full & !pop):
//   - no write; drop_count++ (saturates at 255);
//   - ovf_flag set (sticky).
//  Accepted push: the record carries the current ovf_flag, then ovf_flag clears.
//   A drop in the same cycle as an accepted push cannot occur (one frame event per cycle).
//  tlast is computed at push time and stored in the FIFO entry (65-bit entry):
//   - tlast = (msg_cnt == FRAMES_PER_MSG-1);
//   - msg_cnt counts accepted pushes and wraps to 0 after the tlast record;
//   - dropped frames do not advance msg_cnt.
//  Latency: frame event in cycle N -> m_axis_tvalid=1 in cycle N+1 if the FIFO was empty.
//  m_axis_tdata/tlast are taken from the FIFO head; tvalid = !empty.
//  AXIS rules:
//   - tvalid never depends on tready;
//   - tdata/tlast are held stable while tvalid & !tready;
//   - tvalid is deasserted only after a handshake that empties the FIFO.
//  enable=0: no new captures; FIFO keeps draining; msg_cnt and seq are held.
//  fifo_level updates in the cycle after push/pop (push&pop -> unchanged).
//  Pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally.
//  full = (level == FIFO_DEPTH); empty = (level == 0).
//  Reset mid-operation: FIFO contents discarded, all state returns to reset values at once.
//  No partial-message recovery.
// STRUCTURE
//  Shared package urbansense_pkg holds:
//   - typedef motion_rec_t (packed struct, 64 bits, fields as above);
//   - constants REC_SEQ_MSB/LSB, REC_MOTION_BIT, REC_OVF_BIT.
//  One sub-module: sync_fifo #(WIDTH=65, DEPTH=FIFO_DEPTH).
//   - single clock, async reset, show-ahead read, level output.
//  Top level holds seq, msg_cnt, ovf_flag, drop_count and the push/pop logic.
// TESTING
//  1. 5 frame_done pulses (enable=1, intensity=0x10+i, tready=1) -> 5 beats.
//     Expected: seq 0..4; tlast only on seq 3; each beat 1 cycle after its pulse.
//  2. tready=0; 6 frames -> fifo_level=4, drop_count=2.
//     Then tready=1 -> 4 beats with seq 0..3, ovf bit=0 on all of them.
//     Next frame: seq=6 with ovf bit=1; the frame after it has ovf=0.
//  3. Full FIFO, frame_done with tready=1 in the same cycle.
//     Expected: push accepted, drop_count unchanged, fifo_level stays 4.
//  4. Backpressure: toggle tready pseudo-randomly over 200 frames.
//     Expected: tdata/tlast stable while stalled, no lost or reordered beats.
//     Reference model checks seq order and tlast every 4th accepted record.
//  5. 65537 frames (tready=1).
//     Expected: seq wraps 0xFFFF->0x0000, tlast cadence unbroken.
//     drop_count forced via 300 drops saturates at 255.
//  6. Assert rst_n mid-stream with 3 records queued.
//     Expected: tvalid=0 at once, level=0, next record seq=0, msg_cnt restarts.
//     enable=0 pulses are ignored with seq held.

Source files
------------

// File: rtl/urbansense_pkg.sv
// Shared record layout for the motion detector to Ascon cipher path.
package urbansense_pkg;

   typedef struct packed {
      logic [15:0] seq;
      logic        motion;
      logic        ovf;
      logic [5:0]  rsvd;
      logic [7:0]  intensity;
      logic [15:0] grid;
      logic [15:0] events;
   } motion_rec_t;

   localparam int REC_SEQ_MSB    = 63;
   localparam int REC_SEQ_LSB    = 48;
   localparam int REC_MOTION_BIT = 47;
   localparam int REC_OVF_BIT    = 46;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; head visible on o_rd_dat while !o_empty, 1-cycle write-to-read.
// Caller must not push when full without a same-cycle pop, nor pop when empty.
module sync_fifo #(
   parameter int WIDTH = 65,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_push,
   input  logic [WIDTH-1:0]       i_wr_dat,
   input  logic                   i_pop,
   output logic [WIDTH-1:0]       o_rd_dat,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_level
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [LVL_W-1:0] r_level;

   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wr_ptr] <= i_wr_dat;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({i_push, i_pop})
            2'b10:   r_level <= r_level + LVL_W'(1);
            2'b01:   r_level <= r_level - LVL_W'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // Empty slots are never exposed, so the unreset memory cannot leak X onto the bus.
   assign o_rd_dat = o_empty ? '0 : r_mem[r_rd_ptr];
   assign o_full   = (r_level == LVL_W'(DEPTH));
   assign o_empty  = (r_level == '0);
   assign o_level  = r_level;

endmodule

// File: rtl/motion_record_packer.sv
// Packs one motion record per frame into a FIFO and streams it as 64-bit AXI-Stream with tlast per message.
// Frame to tvalid is one cycle when empty; a frame arriving on a full FIFO with no pop is dropped and counted.
module motion_record_packer
   import urbansense_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int FRAMES_PER_MSG = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        enable,
   input  logic                        frame_done,
   input  logic                        motion_detected,
   input  logic [7:0]                  motion_intensity,
   input  logic [15:0]                 grid_activity,
   input  logic [15:0]                 event_count,
   output logic                        m_axis_tvalid,
   input  logic                        m_axis_tready,
   output logic [63:0]                 m_axis_tdata,
   output logic                        m_axis_tlast,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic [7:0]                  drop_count
);
   localparam int MSG_W = (FRAMES_PER_MSG > 1) ? $clog2(FRAMES_PER_MSG) : 1;

   logic [15:0]      r_seq;
   logic [MSG_W-1:0] r_msg_cnt;
   logic             r_ovf_flag;
   logic [7:0]       r_drop_count;

   logic        w_frame;
   logic        w_push;
   logic        w_pop;
   logic        w_drop;
   logic        w_full;
   logic        w_empty;
   logic        w_tlast;
   motion_rec_t w_rec;
   logic [64:0] w_wr_dat;
   logic [64:0] w_rd_dat;

   assign w_frame = frame_done & enable;
   assign w_pop   = m_axis_tvalid & m_axis_tready;
   assign w_push  = w_frame & (!w_full | w_pop);
   assign w_drop  = w_frame & w_full & !w_pop;
   assign w_tlast = (r_msg_cnt == MSG_W'(FRAMES_PER_MSG - 1));

   always_comb begin
      w_rec           = '0;
      w_rec.seq       = r_seq;
      w_rec.motion    = motion_detected;
      w_rec.ovf       = r_ovf_flag;
      w_rec.intensity = motion_intensity;
      w_rec.grid      = grid_activity;
      w_rec.events    = event_count;
   end

   // tlast travels with the record so stalls downstream cannot shift the message boundary.
   assign w_wr_dat = {w_tlast, w_rec};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seq        <= '0;
         r_msg_cnt    <= '0;
         r_ovf_flag   <= 1'b0;
         r_drop_count <= '0;
      end else begin
         if (w_frame) r_seq <= r_seq + 16'd1;
         if (w_push) begin
            r_ovf_flag <= 1'b0;
            r_msg_cnt  <= w_tlast ? '0 : r_msg_cnt + MSG_W'(1);
         end else if (w_drop) begin
            r_ovf_flag <= 1'b1;
            if (r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 8'd1;
         end
      end
   end

   sync_fifo #(
      .WIDTH (65),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_push   (w_push),
      .i_wr_dat (w_wr_dat),
      .i_pop    (w_pop),
      .o_rd_dat (w_rd_dat),
      .o_full   (w_full),
      .o_empty  (w_empty),
      .o_level  (fifo_level)
   );

   assign m_axis_tvalid = !w_empty;
   assign m_axis_tdata  = w_rd_dat[63:0];
   assign m_axis_tlast  = w_rd_dat[64];
   assign drop_count    = r_drop_count;

endmodule

// File: tb/tb_motion_record_packer.sv
// Scoreboard bench for motion_record_packer: a cycle model predicts every beat, level and drop count.
module tb_motion_record_packer;
   import urbansense_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic        frame_done;
   logic        motion_detected;
   logic [7:0]  motion_intensity;
   logic [15:0] grid_activity;
   logic [15:0] event_count;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic [63:0] m_axis_tdata;
   logic        m_axis_tlast;
   logic [2:0]  fifo_level;
   logic [7:0]  drop_count;

   int n_vec = 0;
   int n_err = 0;

   logic [64:0] sb_q[$];
   logic [15:0] m_seq;
   int          m_msg;
   logic        m_ovf;
   int          m_drop;

   motion_record_packer #(.FIFO_DEPTH(4), .FRAMES_PER_MSG(4)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .enable           (enable),
      .frame_done       (frame_done),
      .motion_detected  (motion_detected),
      .motion_intensity (motion_intensity),
      .grid_activity    (grid_activity),
      .event_count      (event_count),
      .m_axis_tvalid    (m_axis_tvalid),
      .m_axis_tready    (m_axis_tready),
      .m_axis_tdata     (m_axis_tdata),
      .m_axis_tlast     (m_axis_tlast),
      .fifo_level       (fifo_level),
      .drop_count       (drop_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_clear();
      sb_q.delete();
      m_seq  = '0;
      m_msg  = 0;
      m_ovf  = 1'b0;
      m_drop = 0;
   endfunction

   // Check outputs mid-cycle, then advance the model across the coming rising edge.
   task automatic tick();
      bit          pop;
      bit          full;
      logic        tl;
      logic [63:0] rec;
      @(negedge clk);
      chk("tvalid", m_axis_tvalid, sb_q.size() != 0);
      if (sb_q.size() != 0) begin
         chk("tdata", m_axis_tdata, sb_q[0][63:0]);
         chk("tlast", m_axis_tlast, sb_q[0][64]);
      end
      chk("level", fifo_level, sb_q.size());
      chk("drops", drop_count, m_drop);
      full = (sb_q.size() == 4);
      pop  = (sb_q.size() != 0) && m_axis_tready;
      if (pop) void'(sb_q.pop_front());
      if (frame_done && enable) begin
         rec = {m_seq, motion_detected, m_ovf, 6'b0, motion_intensity, grid_activity, event_count};
         m_seq = m_seq + 16'd1;
         if (!full || pop) begin
            tl = (m_msg == 3);
            sb_q.push_back({tl, rec});
            m_ovf = 1'b0;
            m_msg = tl ? 0 : m_msg + 1;
         end else begin
            if (m_drop != 255) m_drop++;
            m_ovf = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic frame(input logic [7:0] inten);
      motion_detected  = 1'($urandom_range(0, 1));
      motion_intensity = inten;
      grid_activity    = 16'($urandom);
      event_count      = 16'($urandom);
      frame_done       = 1'b1;
      tick();
      frame_done       = 1'b0;
   endtask

   task automatic do_reset();
      rst_n         = 1'b0;
      frame_done    = 1'b0;
      enable        = 1'b1;
      m_axis_tready = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_tvalid", m_axis_tvalid, 0);
      chk("rst_tdata", m_axis_tdata, 0);
      chk("rst_tlast", m_axis_tlast, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_drops", drop_count, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      enable = 1'b1;
      frame_done = 1'b0;
      motion_detected = 1'b0;
      motion_intensity = '0;
      grid_activity = '0;
      event_count = '0;
      m_axis_tready = 1'b0;

      // Five spaced frames, consumer always ready
      do_reset();
      m_axis_tready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         frame(8'(8'h10 + i));
         chk("t1_seq", m_axis_tdata[REC_SEQ_MSB:REC_SEQ_LSB], 16'(i));
         chk("t1_last", m_axis_tlast, i == 3);
         tick();
      end
      repeat (2) tick();

      // Overflow: six frames into a stalled FIFO, then drain
      do_reset();
      for (int i = 0; i < 6; i++) frame(8'(i));
      chk("t2_level", fifo_level, 4);
      chk("t2_drops", drop_count, 2);
      m_axis_tready = 1'b1;
      repeat (4) tick();
      frame(8'h66);
      chk("t2_seq6", m_axis_tdata[REC_SEQ_MSB:REC_SEQ_LSB], 6);
      chk("t2_ovf_set", m_axis_tdata[REC_OVF_BIT], 1);
      frame(8'h77);
      chk("t2_ovf_clr", m_axis_tdata[REC_OVF_BIT], 0);
      repeat (2) tick();

      // Full FIFO with frame and pop in the same cycle
      do_reset();
      for (int i = 0; i < 4; i++) frame(8'(i));
      m_axis_tready = 1'b1;
      frame(8'hAA);
      chk("t3_level", fifo_level, 4);
      chk("t3_drops", drop_count, 0);
      repeat (6) tick();

      // Random backpressure over 200 frames
      do_reset();
      for (int n = 0; n < 200; ) begin
         m_axis_tready = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 1) begin
            frame(8'($urandom));
            n++;
         end else begin
            tick();
         end
      end
      m_axis_tready = 1'b1;
      repeat (6) tick();

      // Sequence wrap, then drop counter saturation
      do_reset();
      m_axis_tready = 1'b1;
      for (int i = 0; i < 65537; i++) frame(8'(i));
      chk("t5_wrap_seq", m_axis_tdata[REC_SEQ_MSB:REC_SEQ_LSB], 16'h0000);
      m_axis_tready = 1'b0;
      tick();
      for (int i = 0; i < 304; i++) frame(8'(i));
      chk("t5_drop_sat", drop_count, 255);
      m_axis_tready = 1'b1;
      repeat (6) tick();

      // Asynchronous reset with records queued, then enable gating
      do_reset();
      for (int i = 0; i < 3; i++) frame(8'(i));
      #2;
      rst_n = 1'b0;
      model_clear();
      #1;
      chk("t6_tvalid", m_axis_tvalid, 0);
      chk("t6_level", fifo_level, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      enable = 1'b0;
      for (int i = 0; i < 3; i++) frame(8'hEE);
      chk("t6_ignored", m_axis_tvalid, 0);
      enable = 1'b1;
      m_axis_tready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         frame(8'(8'h30 + i));
         chk("t6_seq", m_axis_tdata[REC_SEQ_MSB:REC_SEQ_LSB], 16'(i));
         chk("t6_last", m_axis_tlast, i == 3);
      end
      repeat (3) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
